// File: rtl/alu_op_sequencer.sv
// Handshaked request/response wrapper around a combinational Alu: registers one operation,
// waits SETTLE cycles, captures the result and counts overflow captures (saturating).
module alu_op_sequencer #(
   parameter int WIDTH  = 32,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_op,
   input  logic             req_unsig,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_unsig,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_compout,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_compout,
   output logic             rsp_overflow,
   output logic             busy,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             clr_count
);

   // state    | meaning
   // S_IDLE   | ready for a request; alu_* hold the previous operation
   // S_SETTLE | operands applied to the Alu, settle timer running
   // S_RESP   | result captured, waiting for rsp_ready
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

   localparam int              TW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [TW-1:0]   TMR_LD = TW'(SETTLE - 1);

   state_t         state, state_nxt;
   logic [TW-1:0]  tmr;
   logic           tmr_tc;
   logic           accept;
   logic           capture;

   assign tmr_tc = (tmr == '0);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (tmr_tc) begin
               capture   = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Outputs decoded from the state register only, so no input reaches them combinationally.
   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign rsp_valid = (state == S_RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (accept) begin
         tmr <= TMR_LD;
      end else if (state == S_SETTLE && !tmr_tc) begin
         tmr <= tmr - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         alu_unsig <= 1'b0;
      end else if (accept) begin
         alu_a     <= req_a;
         alu_b     <= req_b;
         alu_op    <= req_op;
         alu_unsig <= req_unsig;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result   <= '0;
         rsp_compout  <= 1'b0;
         rsp_overflow <= 1'b0;
      end else if (capture) begin
         rsp_result   <= alu_out;
         rsp_compout  <= alu_compout;
         rsp_overflow <= alu_overflow;
      end
   end

   // Clear wins over a same-cycle increment; count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= '0;
      end else if (clr_count) begin
         ovf_count <= '0;
      end else if (capture && alu_overflow && !(&ovf_count)) begin
         ovf_count <= ovf_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three instances (SETTLE=1, SETTLE=3, CNT_W=2), each driving a
// behavioural Alu; expected responses are queued at accept and compared at the response.
module tb_alu_op_sequencer;

   typedef struct {
      int          d;
      logic [31:0] res;
      logic        comp;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid [3];
   logic        req_ready [3];
   logic [31:0] req_a     [3];
   logic [31:0] req_b     [3];
   logic [2:0]  req_op    [3];
   logic        req_unsig [3];
   logic [31:0] alu_a     [3];
   logic [31:0] alu_b     [3];
   logic [2:0]  alu_op    [3];
   logic        alu_unsig [3];
   logic [31:0] alu_out   [3];
   logic        alu_comp  [3];
   logic        alu_ovf   [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_result[3];
   logic        rsp_comp  [3];
   logic        rsp_ovf   [3];
   logic        busy      [3];
   logic        clr_count [3];
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt [3];
   exp_t sb[$];

   // Reference Alu: and/or/add/xor/sub/slt, overflow is carry in unsigned mode.
   function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic u);
      logic [32:0] s;
      logic [31:0] r;
      logic        lt, v;
      lt = u ? (a < b) : ($signed(a) < $signed(b));
      v  = 1'b0;
      r  = '0;
      s  = '0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b011: r = a ^ b;
         3'b010: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            v = u ? s[32] : ((a[31] == b[31]) && (r[31] != a[31]));
         end
         3'b110: begin
            s = {1'b0, a} - {1'b0, b};
            r = s[31:0];
            v = u ? s[32] : ((a[31] != b[31]) && (r[31] != a[31]));
         end
         3'b111: r = {31'd0, lt};
         default: r = '0;
      endcase
      return {v, lt, r};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_alu
      assign {alu_ovf[g], alu_comp[g], alu_out[g]} = alu_f(alu_a[g], alu_b[g], alu_op[g], alu_unsig[g]);
   end

   alu_op_sequencer #(.WIDTH(32), .SETTLE(1), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]), .req_unsig(req_unsig[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_unsig(alu_unsig[0]),
      .alu_out(alu_out[0]), .alu_compout(alu_comp[0]), .alu_overflow(alu_ovf[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
      .rsp_compout(rsp_comp[0]), .rsp_overflow(rsp_ovf[0]), .busy(busy[0]),
      .ovf_count(cnt0), .clr_count(clr_count[0]));

   alu_op_sequencer #(.WIDTH(32), .SETTLE(3), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]), .req_unsig(req_unsig[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_unsig(alu_unsig[1]),
      .alu_out(alu_out[1]), .alu_compout(alu_comp[1]), .alu_overflow(alu_ovf[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
      .rsp_compout(rsp_comp[1]), .rsp_overflow(rsp_ovf[1]), .busy(busy[1]),
      .ovf_count(cnt1), .clr_count(clr_count[1]));

   alu_op_sequencer #(.WIDTH(32), .SETTLE(1), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_a(req_a[2]), .req_b(req_b[2]), .req_op(req_op[2]), .req_unsig(req_unsig[2]),
      .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_op(alu_op[2]), .alu_unsig(alu_unsig[2]),
      .alu_out(alu_out[2]), .alu_compout(alu_comp[2]), .alu_overflow(alu_ovf[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_result(rsp_result[2]),
      .rsp_compout(rsp_comp[2]), .rsp_overflow(rsp_ovf[2]), .busy(busy[2]),
      .ovf_count(cnt2), .clr_count(clr_count[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int settle_of(input int d);
      return (d == 1) ? 3 : 1;
   endfunction

   function automatic int cnt_max(input int d);
      return (d == 2) ? 3 : 65535;
   endfunction

   function automatic logic [31:0] get_cnt(input int d);
      case (d)
         0:       return {16'd0, cnt0};
         1:       return {16'd0, cnt1};
         default: return {30'd0, cnt2};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Starts and ends on a negedge. With pend set, a second request is held on the channel
   // during the stall and left asserted after the response handshake.
   task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic u, input int stall, input bit clr,
                         input bit pend, input logic [31:0] pa, input logic [31:0] pb,
                         input logic [2:0] pop_);
      logic [33:0] r;
      exp_t        e;
      int          n;
      chk("req_ready_idle", req_ready[d], 1);
      req_valid[d] = 1'b1;
      req_a[d] = a; req_b[d] = b; req_op[d] = op; req_unsig[d] = u;
      @(posedge clk);
      r = alu_f(a, b, op, u);
      sb.push_back('{d: d, res: r[31:0], comp: r[32], ovf: r[33]});
      @(negedge clk);
      req_valid[d] = 1'b0;
      chk("alu_a", alu_a[d], a);
      chk("alu_b", alu_b[d], b);
      chk("alu_op", {29'd0, alu_op[d]}, {29'd0, op});
      chk("alu_unsig", {31'd0, alu_unsig[d]}, {31'd0, u});
      chk("busy", {31'd0, busy[d]}, 1);
      n = 0;
      while (!rsp_valid[d] && n < 20) begin
         clr_count[d] = clr && (n == settle_of(d) - 1);
         @(posedge clk);
         @(negedge clk);
         clr_count[d] = 1'b0;
         n++;
      end
      chk("latency", n, settle_of(d));
      e = sb.pop_front();
      chk("rsp_result", rsp_result[d], e.res);
      chk("rsp_compout", {31'd0, rsp_comp[d]}, {31'd0, e.comp});
      chk("rsp_overflow", {31'd0, rsp_ovf[d]}, {31'd0, e.ovf});
      if (clr)                                    exp_cnt[d] = 0;
      else if (e.ovf && exp_cnt[d] < cnt_max(d)) exp_cnt[d]++;
      chk("ovf_count", get_cnt(d), exp_cnt[d]);
      for (int i = 0; i < stall; i++) begin
         if (pend) begin
            req_valid[d] = 1'b1;
            req_a[d] = pa; req_b[d] = pb; req_op[d] = pop_; req_unsig[d] = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         chk("bp_rsp_valid", {31'd0, rsp_valid[d]}, 1);
         chk("bp_rsp_result", rsp_result[d], e.res);
         chk("bp_req_ready", {31'd0, req_ready[d]}, 0);
         chk("bp_alu_a", alu_a[d], a);
         chk("bp_alu_b", alu_b[d], b);
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      chk("post_rsp_valid", {31'd0, rsp_valid[d]}, 0);
      chk("post_req_ready", {31'd0, req_ready[d]}, 1);
      chk("post_rsp_result", rsp_result[d], e.res);
      chk("post_alu_a", alu_a[d], a);
   endtask

   initial begin
      int seen;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; clr_count[d] = 1'b0;
         req_a[d] = '0; req_b[d] = '0; req_op[d] = '0; req_unsig[d] = 1'b0;
         exp_cnt[d] = 0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_req_ready", {31'd0, req_ready[d]}, 1);
         chk("rst_busy", {31'd0, busy[d]}, 0);
         chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 0);
         chk("rst_alu_a", alu_a[d], 0);
         chk("rst_rsp_result", rsp_result[d], 0);
         chk("rst_ovf_count", get_cnt(d), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      run_op(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b0, 0, 1'b0, 1'b0, 0, 0, 3'b000);
      run_op(0, 32'd1, 32'd2, 3'b010, 1'b0, 0, 1'b0, 1'b0, 0, 0, 3'b000);
      run_op(0, 32'd5, 32'd9, 3'b110, 1'b0, 5, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd1, 3'b010);
      run_op(0, 32'h7FFFFFFF, 32'd1, 3'b010, 1'b0, 0, 1'b0, 1'b0, 0, 0, 3'b000);
      run_op(0, 32'hFFFFFFFF, 32'd1, 3'b010, 1'b1, 1, 1'b0, 1'b0, 0, 0, 3'b000);
      run_op(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 1'b0, 0, 1'b0, 1'b0, 0, 0, 3'b000);
      run_op(0, 32'h8000_0000, 32'd3, 3'b111, 1'b0, 0, 1'b0, 1'b0, 0, 0, 3'b000);
      run_op(0, 32'h8000_0000, 32'd3, 3'b111, 1'b1, 0, 1'b0, 1'b0, 0, 0, 3'b000);
      run_op(0, 32'h8000_0000, 32'd1, 3'b110, 1'b0, 2, 1'b0, 1'b0, 0, 0, 3'b000);

      run_op(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b0, 1, 1'b0, 1'b0, 0, 0, 3'b000);

      for (int k = 0; k < 6; k++)
         run_op(2, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b0, 0, (k == 5), 1'b0, 0, 0, 3'b000);

      // Abort a SETTLE=3 transaction with reset while its timer is running.
      req_valid[1] = 1'b1;
      req_a[1] = 32'h7FFFFFFF; req_b[1] = 32'h7FFFFFFF; req_op[1] = 3'b010; req_unsig[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      chk("abort_busy", {31'd0, busy[1]}, 1);
      chk("abort_alu_a", alu_a[1], 32'h7FFFFFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_rsp_valid", {31'd0, rsp_valid[1]}, 0);
      chk("abort_alu_a_rst", alu_a[1], 0);
      chk("abort_ovf_count", get_cnt(1), 0);
      for (int d = 0; d < 3; d++) exp_cnt[d] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_req_ready", {31'd0, req_ready[1]}, 1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) seen++;
      end
      chk("abort_no_rsp", seen, 0);
      chk("abort_cnt_after", get_cnt(1), 0);

      run_op(1, 32'd1, 32'd2, 3'b010, 1'b0, 0, 1'b0, 1'b0, 0, 0, 3'b000);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Request-side driver for the 32-bit `Alu`. It accepts one operation at a time over a valid/ready request channel and drives the registered operands and opcode into an `Alu` instance. After a fixed settle interval it captures `aluout`/`compout`/`overflow` and returns them on a valid/ready response channel. It also keeps a saturating count of captured overflow events, so that test sequencers and future datapath control logic can use the ALU as a handshaked unit.

## Interface
- `WIDTH`, 32, operand/result width
- `SETTLE`, 1, cycles from operand registration to result capture (legal ≥1)
- `CNT_W`, 16, width of overflow event counter

- `clk` in 1: single clock; all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: sequencer can accept; equals (state==IDLE)
- `req_a`, `req_b` in WIDTH: operands
- `req_op` in 3: ALU opcode, passed through unchanged
- `req_unsig` in 1: unsigned-mode flag, passed through
- `alu_a`, `alu_b` out WIDTH: registered operands to `Alu`
- `alu_op` out 3, `alu_unsig` out 1: registered controls to `Alu`
- `alu_out` in WIDTH, `alu_compout` in 1, `alu_overflow` in 1: `Alu` results
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: consumer accepts response
- `rsp_result` out WIDTH, `rsp_compout` out 1, `rsp_overflow` out 1: captured results
- `busy` out 1: state != IDLE
- `ovf_count` out CNT_W: saturating count of captures with `alu_overflow`=1
- `clr_count` in 1: synchronous clear of `ovf_count`

## Operation
- FSM states are IDLE, SETTLE, RESP. On reset the FSM is in IDLE.
- **IDLE:** `req_ready`=1.
  - On `req_valid`: register `req_a`/`req_b`/`req_op`/`req_unsig` into `alu_*`, load the settle counter with SETTLE-1, and go to SETTLE.
- **SETTLE:** if the counter is 0, capture `alu_out`/`alu_compout`/`alu_overflow` into `rsp_*`, set `rsp_valid`, and go to RESP. Otherwise decrement the counter.
- **RESP:** `rsp_valid`=1 and all `rsp_*` are held stable.
  - On `rsp_ready`: clear `rsp_valid` and go to IDLE.
  - `rsp_result`/`rsp_compout`/`rsp_overflow` keep their last values after the handshake.
- `alu_*` outputs hold the last accepted request until the next accept, so the `Alu` inputs never glitch during SETTLE or RESP.
- `req_valid` outside IDLE is ignored; there is no queueing. The requester must hold its request until `req_ready`.
- **Overflow counter:**
  - Increments by 1 on the capture edge when `alu_overflow`=1.
  - Saturates at all-ones with no wrap.
  - `clr_count` has priority over a same-cycle increment, and the result is 0.
- The sequencer does not interpret `req_op` or `req_unsig`; it passes them through. Result arithmetic is the `Alu`'s.
- **Reset values:**
  - State IDLE; `req_ready`=1 once reset is applied.
  - `busy`=0, `rsp_valid`=0.
  - `alu_a`, `alu_b`, `alu_op`, `alu_unsig`, `rsp_result`, `rsp_compout`, `rsp_overflow` and `ovf_count` are all 0.
- **Reset mid-operation** (SETTLE or RESP): the transaction is dropped, no response is produced, and the counter is cleared.

## Timing
- Request accepted on edge k (`req_valid`&`req_ready`). `alu_*` are valid after edge k.
- Capture happens on edge k+SETTLE. `rsp_valid` is high from edge k+SETTLE until the edge where `rsp_ready`=1.
- Request-to-response latency is SETTLE cycles.
- Response handshake on edge m means `req_ready`=1 after edge m, so the next accept is at edge m+1 at the earliest.
- Minimum issue interval is SETTLE+2 cycles with `rsp_ready` tied high.
- `ovf_count` reflects a capture after the capture edge.
- `req_ready` and `busy` are decoded from the state register only, with no combinational path from any input.

## Test plan
Bench instantiates `Alu` behind the sequencer.
- **Reset mid-op:**
  - Stimulus: accept a request with SETTLE=3, then assert `rst_n`=0 during SETTLE.
  - Required: `rsp_valid`=0, `alu_a`=0 and `ovf_count`=0 immediately. After release, `req_ready`=1 and no response ever appears.
- **Signed overflow:**
  - Stimulus: a=32'h7FFFFFFF, b=32'h7FFFFFFF, op=3'b010, unsig=0, SETTLE=1.
  - Required: `rsp_valid` rises 1 cycle after accept with `rsp_result`=32'hFFFFFFFE, `rsp_overflow`=1 and `ovf_count`=1.
- **No overflow:**
  - Stimulus: a=1, b=2, op=3'b010, unsig=0.
  - Required: `rsp_result`=3, `rsp_overflow`=0, `ovf_count` unchanged.
- **Backpressure:**
  - Stimulus: hold `rsp_ready`=0 for 5 cycles while a second `req_valid` is asserted.
  - Required: `rsp_*` stable, `req_ready`=0 and `alu_*` unchanged throughout. The second request is accepted exactly 1 cycle after the response handshake.
- **Latency parameter:**
  - Stimulus: SETTLE=3, same operands as the signed-overflow case.
  - Required: `rsp_valid` rises exactly 3 cycles after accept.
- **Counter saturation and clear:**
  - Stimulus: CNT_W=2 with five overflowing ops, then `clr_count`=1 on the capture edge of a sixth overflowing op.
  - Required: `ovf_count` reads 1, 2, 3, 3, 3, then 0 after the sixth op.
